nand_cmd_sequencer: RTL and testbench
=====================================

// Module: nand_cmd_sequencer
// PURPOSE
// - Upstream master for the NAND Avalon register bridge: runs per-byte command jobs on its register port.
// - Job = command code x COUNT iterations; each iteration optionally loads a write byte, issues the command, waits for not-busy, optionally returns a read byte.
// - Relieves software of the write/poll/read loop. Bridge map: addr 0 data I/O, addr 1 command, addr 2 status (bit0 = busy).
// PARAMETERS
// - CNT_W    16   width of job_count
// - SETTLE   4    idle cycles after a command write before busy is first sampled (min 2)
// - TIMEOUT  4096 poll-cycle limit per iteration (used only with NAND_SEQ_TIMEOUT_EN)
// PORTS
// - clk        in  1      system clock
// - reset      in  1      asynchronous, active-high reset
// - job_valid  in  1      job request; accepted when job_valid & job_ready
// - job_ready  out 1      high only in IDLE
// - job_cmd    in  8      command code written to bridge addr 1
// - job_count  in  CNT_W  iteration count; 0 = empty job
// - job_wr     in  1      each iteration consumes one wr byte
// - job_rd     in  1      each iteration produces one rd byte
// - wr_valid   in  1      write-byte stream valid
// - wr_ready   out 1      write-byte stream ready
// - wr_data    in  8      write byte
// - rd_valid   out 1      read-byte stream valid
// - rd_ready   in  1      read-byte stream ready
// - rd_data    out 8      read byte
// - done       out 1      1-cycle pulse at job end
// - err        out 1      1-cycle pulse with done on timeout abort
// - address    out 2      bridge register address
// - writedata  out 32     bridge write data; bits 31:8 always 0
// - pwrite     out 1      bridge write strobe, active-low
// - pread      out 1      bridge read strobe, active-low
// - readdata   in  32     bridge read data; valid 1 cycle after address change
// BEHAVIOUR
// - Reset: IDLE; pwrite=1, pread=1, address=0, writedata=0, rd_valid=0, rd_data=0, wr_ready=0, done=0, err=0; counters 0.
// - Reset mid-job abandons the job; no done pulse is issued.
// - Bus write = 1 cycle with pwrite=0, address/writedata stable; next cycle pwrite=1 with the same address.
// - No two write pulses are issued back-to-back.
// - IDLE: job accepted -> latch job fields, iter=job_count. count=0 -> done next cycle, no bus traffic.
// - Else -> WR_WAIT if job_wr, otherwise CMD.
// - WR_WAIT: wr_ready=1; on wr_valid & wr_ready -> 1-cycle write to addr 0 with {24'b0,wr_data} -> CMD.
// - CMD: write job_cmd to addr 1 (pulse + 1 hold cycle) -> SETTLE.
// - SETTLE: SETTLE idle cycles; on entry address=2 -> POLL.
// - POLL: pread=0, address=2; readdata[0]==0 -> RD (if job_rd) or NEXT; otherwise stay.
// - RD: address=0, pread=0; wait 1 cycle; capture readdata[7:0] into rd_data; rd_valid=1.
// - RD: hold rd_valid and rd_data until rd_ready -> NEXT. Next iteration never starts while a rd byte is pending.
// - NEXT: iter-=1; iter==0 -> done=1 for 1 cycle -> IDLE; else WR_WAIT or CMD as above.
// - wr_ready is high only in WR_WAIT. wr_valid with no job pending is ignored (no byte consumed).
// - Job fields are sampled at accept only; changes during a job have no effect.
// - Iteration counter is unsigned CNT_W; max job = 2^CNT_W-1 iterations; no wrap.
// - pread is high in every state other than POLL and RD.
// CONFIGURATION
// - NAND_SEQ_TIMEOUT_EN defined: POLL counts cycles.
// - At TIMEOUT cycles still busy: done=1 and err=1 in the same cycle -> IDLE; remaining iterations dropped; no rd byte for that iteration.
// - NAND_SEQ_TIMEOUT_EN undefined: POLL waits indefinitely; err is tied to 0; TIMEOUT is unused.
// TESTING
// - Reset mid-POLL -> next cycle pwrite=1, pread=1, address=0, job_ready=1, no done.
// - job cmd=0x05, count=1, no wr/rd; busy model high 6 cycles -> one addr-1 pulse writedata=0x05; done 1 cycle after busy reads 0.
// - cmd=0x0A, count=3, job_wr, wr bytes 0x11/0x22/0x33 -> three addr-0 writes then addr-1 writes, in order, each followed by poll; one done.
// - cmd=0x0B, count=2, job_rd, model returns 0xA5 then 0x5A, rd_ready low 5 cycles -> rd_data held; no 2nd cmd until accept; bytes in order.
// - count=0 -> done 1 cycle after accept; pwrite stays 1 throughout.
// - NAND_SEQ_TIMEOUT_EN, TIMEOUT=16, busy stuck 1 -> done=err=1 after 16 poll cycles; job_ready next cycle.

Source files
------------

// File: rtl/nand_cmd_sequencer_if.sv
// Register-bus interface between the NAND command sequencer (master) and the
// NAND Avalon register bridge (slave).
// Bridge map: addr 0 = data I/O, addr 1 = command, addr 2 = status (bit0 busy).
// pwrite and pread are active-low strobes. readdata is valid one cycle after
// address changes.
interface nand_cmd_sequencer_if;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic        pwrite;
  logic        pread;
  logic [31:0] readdata;

  modport master (
    output address,
    output writedata,
    output pwrite,
    output pread,
    input  readdata
  );

  modport slave (
    input  address,
    input  writedata,
    input  pwrite,
    input  pread,
    output readdata
  );
endinterface

// File: rtl/nand_cmd_sequencer.sv
// NAND command sequencer: runs per-byte command jobs on the NAND bridge
// register port. Each iteration optionally writes a data byte (addr 0), writes
// the command (addr 1), waits SETTLE cycles, polls status (addr 2) until not
// busy, then optionally reads a data byte (addr 0) back to the rd stream.
// Optional feature macro: NAND_SEQ_TIMEOUT_EN. When it is defined, polling
// aborts the job after TIMEOUT busy cycles and pulses done together with err.
// When it is undefined, polling waits forever and err is always 0.
module nand_cmd_sequencer #(
  parameter int CNT_W   = 16,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [7:0]           job_cmd,
  input  logic [CNT_W-1:0]     job_count,
  input  logic                 job_wr,
  input  logic                 job_rd,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [7:0]           wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [7:0]           rd_data,
  output logic                 done,
  output logic                 err,
  nand_cmd_sequencer_if.master bus
);

  localparam int SW = $clog2(SETTLE + 1);

  // Reject parameter values the settle/poll timing cannot work with.
  if (SETTLE < 2 || TIMEOUT < 1) begin : g_param_check
    $error("nand_cmd_sequencer: SETTLE must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_WAIT,
    S_WR_PULSE,
    S_WR_HOLD,
    S_CMD,
    S_CMD_HOLD,
    S_SETTLE,
    S_POLL,
    S_RD_ADDR,
    S_RD_CAP,
    S_RD_HOLD,
    S_NEXT,
    S_DONE,
    S_ABORT
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [7:0]       cmd_q;
  logic             wr_q;
  logic             rd_q;
  logic [CNT_W-1:0] iter;
  logic [7:0]       wr_byte;
  logic [7:0]       rd_data_q;
  logic [SW-1:0]    settle_cnt;
  logic             unused_readdata;

  assign unused_readdata = ^bus.readdata[31:8];
  assign rd_data         = rd_data_q;

`ifdef NAND_SEQ_TIMEOUT_EN
  localparam int PW = $clog2(TIMEOUT + 1);
  logic [PW-1:0] poll_cnt;

  // Count busy poll cycles in the current iteration; restart on every POLL entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= (state == S_POLL) ? poll_cnt + 1'b1 : '0;
    end
  end
`endif

  // State register; reset abandons any job in flight without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Job fields are captured at accept only, so upstream may change them mid-job.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q      <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      iter       <= '0;
      wr_byte    <= '0;
      rd_data_q  <= '0;
      settle_cnt <= '0;
    end else begin
      if (state == S_IDLE && job_valid) begin
        cmd_q <= job_cmd;
        wr_q  <= job_wr;
        rd_q  <= job_rd;
        iter  <= job_count;
      end
      if (state == S_WR_WAIT && wr_valid) begin
        wr_byte <= wr_data;
      end
      if (state == S_RD_CAP) begin
        rd_data_q <= bus.readdata[7:0];
      end
      if (state == S_NEXT) begin
        iter <= iter - 1'b1;
      end
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;
    end
  end

  // Next-state logic: one pass through the write/command/poll/read loop per iteration.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (job_valid) begin
          if (job_count == '0)  next_state = S_DONE;
          else if (job_wr)      next_state = S_WR_WAIT;
          else                  next_state = S_CMD;
        end
      end
      S_WR_WAIT:  if (wr_valid) next_state = S_WR_PULSE;
      S_WR_PULSE: next_state = S_WR_HOLD;
      S_WR_HOLD:  next_state = S_CMD;
      S_CMD:      next_state = S_CMD_HOLD;
      S_CMD_HOLD: next_state = S_SETTLE;
      S_SETTLE: begin
        if (settle_cnt == SW'(SETTLE - 1)) next_state = S_POLL;
      end
      S_POLL: begin
        if (!bus.readdata[0]) begin
          next_state = rd_q ? S_RD_ADDR : S_NEXT;
        end
`ifdef NAND_SEQ_TIMEOUT_EN
        else if (poll_cnt == PW'(TIMEOUT - 1)) begin
          next_state = S_ABORT;
        end
`endif
      end
      S_RD_ADDR:  next_state = S_RD_CAP;
      S_RD_CAP:   next_state = S_RD_HOLD;
      S_RD_HOLD:  if (rd_ready) next_state = S_NEXT;
      S_NEXT: begin
        if (iter == CNT_W'(1)) next_state = S_IDLE;
        else if (wr_q)         next_state = S_WR_WAIT;
        else                   next_state = S_CMD;
      end
      S_DONE:     next_state = S_IDLE;
      S_ABORT:    next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Output decode: bus strobes idle high, each write pulse is followed by a hold cycle.
  always_comb begin
    bus.address   = 2'd0;
    bus.writedata = 32'd0;
    bus.pwrite    = 1'b1;
    bus.pread     = 1'b1;
    job_ready     = 1'b0;
    wr_ready      = 1'b0;
    rd_valid      = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    case (state)
      S_IDLE:    job_ready = 1'b1;
      S_WR_WAIT: wr_ready  = 1'b1;
      S_WR_PULSE: begin
        bus.address   = 2'd0;
        bus.writedata = {24'd0, wr_byte};
        bus.pwrite    = 1'b0;
      end
      S_WR_HOLD: begin
        bus.address   = 2'd0;
        bus.writedata = {24'd0, wr_byte};
      end
      S_CMD: begin
        bus.address   = 2'd1;
        bus.writedata = {24'd0, cmd_q};
        bus.pwrite    = 1'b0;
      end
      S_CMD_HOLD: begin
        bus.address   = 2'd1;
        bus.writedata = {24'd0, cmd_q};
      end
      S_SETTLE:  bus.address = 2'd2;
      S_POLL: begin
        bus.address = 2'd2;
        bus.pread   = 1'b0;
      end
      S_RD_ADDR, S_RD_CAP: begin
        bus.address = 2'd0;
        bus.pread   = 1'b0;
      end
      S_RD_HOLD: begin
        bus.address = 2'd0;
        bus.pread   = 1'b0;
        rd_valid    = 1'b1;
      end
      S_NEXT:    done = (iter == CNT_W'(1));
      S_DONE:    done = 1'b1;
      S_ABORT: begin
        done = 1'b1;
`ifdef NAND_SEQ_TIMEOUT_EN
        err  = 1'b1;
`endif
      end
      default: begin
        bus.address = 2'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_nand_cmd_sequencer.sv
// Directed self-checking bench for nand_cmd_sequencer with a small behavioural
// model of the NAND register bridge (busy countdown, per-command read bytes).
// Timeout test runs only when NAND_SEQ_TIMEOUT_EN is defined.
module tb_nand_cmd_sequencer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             job_valid;
  logic             job_ready;
  logic [7:0]       job_cmd;
  logic [CNT_W-1:0] job_count;
  logic             job_wr;
  logic             job_rd;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [7:0]       rd_data;
  logic             done;
  logic             err;

  nand_cmd_sequencer_if bus ();

  nand_cmd_sequencer #(
    .CNT_W   (CNT_W),
    .SETTLE  (4),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_cmd   (job_cmd),
    .job_count (job_count),
    .job_wr    (job_wr),
    .job_rd    (job_rd),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Bridge model state
  int         busy_len = 0;
  int         busy_left = 0;
  logic       stuck = 1'b0;
  logic [2:0] cmd_seen = 3'd0;
  logic [7:0] rd_table [8];

  // Bus monitor state
  typedef struct packed {
    logic [1:0] a;
    logic [7:0] d;
  } wr_ev_t;
  wr_ev_t     wlog[$];
  int         done_count = 0;
  int         poll_starts = 0;
  int         b2b_count = 0;
  int         hold_err_count = 0;
  int         upper_err_count = 0;
  logic       prev_pw_low = 1'b0;
  logic       prev_poll = 1'b0;
  logic [1:0] prev_addr = 2'd0;

  // Bridge model: command write starts a busy countdown; readdata is registered.
  always @(posedge clk) begin
    if (reset) begin
      busy_left    <= 0;
      cmd_seen     <= 3'd0;
      bus.readdata <= 32'd0;
    end else begin
      if (!bus.pwrite && bus.address == 2'd1) begin
        busy_left <= busy_len;
        cmd_seen  <= cmd_seen + 3'd1;
      end else if (busy_left != 0) begin
        busy_left <= busy_left - 1;
      end
      case (bus.address)
        2'd2:    bus.readdata <= {31'd0, (busy_left != 0) || stuck};
        2'd0:    bus.readdata <= {24'd0, rd_table[cmd_seen]};
        default: bus.readdata <= 32'd0;
      endcase
    end
  end

  // Bus monitor: logs write pulses, counts done pulses and poll phases, flags protocol slips.
  always @(posedge clk) begin
    wr_ev_t ev;
    if (done) done_count++;
    if (!bus.pwrite) begin
      ev.a = bus.address;
      ev.d = bus.writedata[7:0];
      wlog.push_back(ev);
      if (prev_pw_low) b2b_count++;
      if (bus.writedata[31:8] != 24'd0) upper_err_count++;
    end
    if (prev_pw_low && bus.address != prev_addr) hold_err_count++;
    if (!bus.pread && bus.address == 2'd2 && !prev_poll) poll_starts++;
    prev_poll   = !bus.pread && bus.address == 2'd2;
    prev_pw_low = !bus.pwrite;
    prev_addr   = bus.address;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wlog(input string tag, input int idx, input logic [1:0] a, input logic [7:0] d);
    wr_ev_t ev;
    ev.a = 2'b11;
    ev.d = 8'hFF;
    if (idx < wlog.size()) ev = wlog[idx];
    check_output(tag, {22'd0, ev.a, ev.d}, {22'd0, a, d});
  endtask

  // Present a job at a negedge; returns at the negedge of the first cycle after accept.
  task automatic apply_job(input logic [7:0] cmd, input logic [CNT_W-1:0] cnt,
                           input logic wr, input logic rd);
    check_output("job_ready_before_accept", {31'd0, job_ready}, 32'd1);
    job_cmd   = cmd;
    job_count = cnt;
    job_wr    = wr;
    job_rd    = rd;
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    job_cmd   = 8'hFF;
    job_count = '1;
    job_wr    = ~wr;
    job_rd    = ~rd;
  endtask

  // Wait for done, counting cycles from the first post-accept cycle (n=1).
  task automatic wait_done(input int bound, output int n, output int nb);
    n  = 1;
    nb = -1;
    while (1) begin
      if (!bus.pread && bus.address == 2'd2 && !bus.readdata[0]) nb = n;
      if (done || n >= bound) break;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_poll(input int bound);
    int n;
    n = 0;
    while (!(!bus.pread && bus.address == 2'd2) && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int         n;
    int         nb;
    int         d0;
    int         p0;
    int         idx;
    logic       took;
    logic       stable;
    logic [2:0] base;
    logic [7:0] wb [3];

    wb[0] = 8'h11;
    wb[1] = 8'h22;
    wb[2] = 8'h33;
    for (int i = 0; i < 8; i++) rd_table[i] = 8'h00;
    reset     = 1'b1;
    job_valid = 1'b0;
    job_cmd   = 8'h00;
    job_count = '0;
    job_wr    = 1'b0;
    job_rd    = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = 8'h00;
    rd_ready  = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_output("rst_pwrite",    {31'd0, bus.pwrite}, 32'd1);
    check_output("rst_pread",     {31'd0, bus.pread},  32'd1);
    check_output("rst_address",   {30'd0, bus.address}, 32'd0);
    check_output("rst_writedata", bus.writedata, 32'd0);
    check_output("rst_outs", {26'd0, job_ready, wr_ready, rd_valid, done, err, 1'b0}, {26'd0, 6'b100000});
    check_output("rst_rd_data",   {24'd0, rd_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_output("post_rst_job_ready", {31'd0, job_ready}, 32'd1);

    // Single command, no data; busy countdown of 6
    $display("[TB] single command job");
    busy_len = 6;
    wlog.delete();
    d0 = done_count;
    apply_job(8'h05, 16'd1, 1'b0, 1'b0);
    wait_done(60, n, nb);
    check_output("t2_done_seen",    {31'd0, done}, 32'd1);
    check_output("t2_done_latency", n, 32'd10);
    check_output("t2_done_after_notbusy", n, nb + 1);
    check_output("t2_err",          {31'd0, err}, 32'd0);
    @(negedge clk);
    check_output("t2_done_one_cycle", {31'd0, done}, 32'd0);
    check_output("t2_ready_again",  {31'd0, job_ready}, 32'd1);
    check_output("t2_write_count",  wlog.size(), 32'd1);
    check_wlog("t2_cmd_write", 0, 2'd1, 8'h05);
    check_output("t2_done_count",   done_count - d0, 32'd1);

    // Stray write bytes while idle are not consumed
    $display("[TB] idle write stream");
    wlog.delete();
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    repeat (3) @(negedge clk);
    check_output("idle_wr_ready", {31'd0, wr_ready}, 32'd0);
    check_output("idle_no_write", wlog.size(), 32'd0);
    wr_valid = 1'b0;

    // Three iterations, each consuming one write byte
    $display("[TB] write job x3");
    busy_len = 3;
    d0 = done_count;
    p0 = poll_starts;
    apply_job(8'h0A, 16'd3, 1'b1, 1'b0);
    idx      = 0;
    wr_valid = 1'b1;
    wr_data  = wb[0];
    n        = 1;
    while (1) begin
      if (done || n >= 300) break;
      took = wr_valid && wr_ready;
      @(negedge clk);
      n++;
      if (took) begin
        idx++;
        if (idx < 3) wr_data = wb[idx];
        else wr_valid = 1'b0;
      end
    end
    wr_valid = 1'b0;
    check_output("t3_done_seen",   {31'd0, done}, 32'd1);
    check_output("t3_bytes_taken", idx, 32'd3);
    @(negedge clk);
    check_output("t3_write_count", wlog.size(), 32'd6);
    check_wlog("t3_w0", 0, 2'd0, 8'h11);
    check_wlog("t3_w1", 1, 2'd1, 8'h0A);
    check_wlog("t3_w2", 2, 2'd0, 8'h22);
    check_wlog("t3_w3", 3, 2'd1, 8'h0A);
    check_wlog("t3_w4", 4, 2'd0, 8'h33);
    check_wlog("t3_w5", 5, 2'd1, 8'h0A);
    check_output("t3_poll_phases", poll_starts - p0, 32'd3);
    check_output("t3_done_count",  done_count - d0, 32'd1);

    // Two iterations returning read bytes, consumer stalls the first one
    $display("[TB] read job x2 with back-pressure");
    busy_len = 2;
    base = cmd_seen;
    rd_table[base + 3'd1] = 8'hA5;
    rd_table[base + 3'd2] = 8'h5A;
    wlog.delete();
    d0 = done_count;
    apply_job(8'h0B, 16'd2, 1'b0, 1'b1);
    n = 0;
    while (!rd_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("t4_rd1_valid", {31'd0, rd_valid}, 32'd1);
    check_output("t4_rd1_data",  {24'd0, rd_data}, 32'h0000_00A5);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!rd_valid || rd_data != 8'hA5) stable = 1'b0;
    end
    check_output("t4_rd1_held",       {31'd0, stable}, 32'd1);
    check_output("t4_no_second_cmd",  wlog.size(), 32'd1);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    check_output("t4_rd1_released", {31'd0, rd_valid}, 32'd0);
    n = 0;
    while (!rd_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("t4_rd2_valid", {31'd0, rd_valid}, 32'd1);
    check_output("t4_rd2_data",  {24'd0, rd_data}, 32'h0000_005A);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    check_output("t4_done",        {31'd0, done}, 32'd1);
    check_output("t4_write_count", wlog.size(), 32'd2);
    check_wlog("t4_cmd0", 0, 2'd1, 8'h0B);
    check_wlog("t4_cmd1", 1, 2'd1, 8'h0B);
    @(negedge clk);
    check_output("t4_done_count", done_count - d0, 32'd1);

    // Empty job: done right after accept, no bus traffic
    $display("[TB] empty job");
    wlog.delete();
    d0 = done_count;
    apply_job(8'h33, 16'd0, 1'b1, 1'b1);
    check_output("t5_done",  {31'd0, done}, 32'd1);
    check_output("t5_err",   {31'd0, err}, 32'd0);
    @(negedge clk);
    check_output("t5_done_one_cycle", {31'd0, done}, 32'd0);
    check_output("t5_ready",          {31'd0, job_ready}, 32'd1);
    check_output("t5_no_writes",      wlog.size(), 32'd0);
    check_output("t5_done_count",     done_count - d0, 32'd1);

    // Reset while polling abandons the job silently
    $display("[TB] reset during poll");
    stuck    = 1'b1;
    busy_len = 0;
    apply_job(8'h07, 16'd2, 1'b0, 1'b0);
    wait_poll(100);
    check_output("t6_in_poll", {31'd0, !bus.pread && bus.address == 2'd2}, 32'd1);
    d0 = done_count;
    reset = 1'b1;
    #1;
    check_output("t6_rst_pwrite",  {31'd0, bus.pwrite}, 32'd1);
    check_output("t6_rst_pread",   {31'd0, bus.pread},  32'd1);
    check_output("t6_rst_address", {30'd0, bus.address}, 32'd0);
    check_output("t6_rst_ready",   {31'd0, job_ready}, 32'd1);
    check_output("t6_rst_done",    {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stuck = 1'b0;
    repeat (3) @(negedge clk);
    check_output("t6_no_done_pulse", done_count - d0, 32'd0);
    check_output("t6_ready_after",   {31'd0, job_ready}, 32'd1);

`ifdef NAND_SEQ_TIMEOUT_EN
    // Busy stuck high: abort after TIMEOUT poll cycles
    $display("[TB] poll timeout");
    stuck = 1'b1;
    wlog.delete();
    apply_job(8'h44, 16'd3, 1'b0, 1'b1);
    wait_poll(100);
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("t7_done",    {31'd0, done}, 32'd1);
    check_output("t7_err",     {31'd0, err}, 32'd1);
    check_output("t7_latency", n, 32'd17);
    @(negedge clk);
    check_output("t7_ready",    {31'd0, job_ready}, 32'd1);
    check_output("t7_err_low",  {31'd0, err}, 32'd0);
    check_output("t7_no_rd",    {31'd0, rd_valid}, 32'd0);
    check_output("t7_one_cmd",  wlog.size(), 32'd1);
    stuck = 1'b0;
    repeat (2) @(negedge clk);
`endif

    // Bus protocol checks gathered over the whole run
    check_output("no_back_to_back_writes", b2b_count, 32'd0);
    check_output("hold_cycle_address",     hold_err_count, 32'd0);
    check_output("writedata_upper_zero",   upper_err_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
